// File: rtl/wb_stage_pipe_if.sv
// Handshake and register-file write bundle for the writeback stage.
// The slave modport is the stage itself; master is whatever drives MEM results and observes writes.
interface wb_stage_pipe_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic               in_regwrite;
    logic [RADDR_W-1:0] in_rd;
    logic [1:0]         in_wb_sel;
    logic [XLEN-1:0]    in_ex_result;
    logic [XLEN-1:0]    in_pc;
    logic [2:0]         in_ld_funct3;
    logic [2:0]         in_addr_lo;
    logic               mem_rsp_valid;
    logic [XLEN-1:0]    mem_rsp_data;
    logic               reg_write_enable;
    logic [RADDR_W-1:0] reg_write_addr;
    logic [XLEN-1:0]    reg_write_data;
    logic               busy;
    logic               mem_timeout_err;

    modport master (
        output in_valid, in_regwrite, in_rd, in_wb_sel, in_ex_result, in_pc,
               in_ld_funct3, in_addr_lo, mem_rsp_valid, mem_rsp_data,
        input  in_ready, reg_write_enable, reg_write_addr, reg_write_data,
               busy, mem_timeout_err
    );

    modport slave (
        input  in_valid, in_regwrite, in_rd, in_wb_sel, in_ex_result, in_pc,
               in_ld_funct3, in_addr_lo, mem_rsp_valid, mem_rsp_data,
        output in_ready, reg_write_enable, reg_write_addr, reg_write_data,
               busy, mem_timeout_err
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// Writeback stage: result select, sub-word load alignment, wait on the data-memory
// response with a watchdog, and a one-cycle register-file write pulse.
module wb_stage_pipe #(
    parameter int XLEN        = 32,
    parameter int PC_STEP     = 4,
    parameter int RADDR_W     = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_stage_pipe_if.slave  bus
);
    localparam int BL = $clog2(XLEN / 8);
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic               regwrite_q, regwrite_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [2:0]         addr_lo_q, addr_lo_d;
    logic               we_q, we_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               accept_s;

    // Shift the addressed lane down to bit 0, then extend according to funct3.
    function automatic logic [XLEN-1:0] align_load(
        input logic [XLEN-1:0] raw,
        input logic [2:0]      f3,
        input logic [2:0]      lo
    );
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        logic [BL-1:0]   boff;
        logic [5:0]      wsh;
        boff = lo[BL-1:0];
        wsh  = (XLEN == 64) ? {lo[2], 5'b00000} : 6'd0;
        case (f3[1:0])
            2'b00:   sh = raw >> {boff, 3'b000};
            2'b01:   sh = raw >> {boff[BL-1:1], 4'b0000};
            2'b10:   sh = raw >> wsh;
            default: sh = raw;
        endcase
        case (f3)
            3'b000:  res = XLEN'(signed'(sh[7:0]));
            3'b100:  res = XLEN'(sh[7:0]);
            3'b001:  res = XLEN'(signed'(sh[15:0]));
            3'b101:  res = XLEN'(sh[15:0]);
            3'b010:  res = XLEN'(signed'(sh[31:0]));
            3'b110:  res = XLEN'(sh[31:0]);
            default: res = raw;
        endcase
        return res;
    endfunction

    assign accept_s = bus.in_valid & ready_q;

    // Next-state, capture and write-pulse logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (bus.in_wb_sel == 2'd1) begin
                        rd_d       = bus.in_rd;
                        regwrite_d = bus.in_regwrite;
                        funct3_d   = bus.in_ld_funct3;
                        addr_lo_d  = bus.in_addr_lo;
                        cnt_d      = '0;
                        state_d    = WAIT_MEM;
                    end else begin
                        we_d    = bus.in_regwrite & (bus.in_rd != '0);
                        waddr_d = bus.in_rd;
                        wdata_d = (bus.in_wb_sel == 2'd2) ? bus.in_pc + XLEN'(PC_STEP)
                                                          : bus.in_ex_result;
                    end
                end else begin
                    we_d = 1'b0;
                end
            end
            WAIT_MEM: begin
                // A response in the final allowed cycle still beats the watchdog.
                if (bus.mem_rsp_valid) begin
                    we_d    = regwrite_q & (rd_q != '0);
                    waddr_d = rd_q;
                    wdata_d = align_load(bus.mem_rsp_data, funct3_q, addr_lo_q);
                    state_d = IDLE;
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == WAIT_MEM);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_lo_q  <= 3'd0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.in_ready         = ready_q;
    assign bus.reg_write_enable = we_q;
    assign bus.reg_write_addr   = waddr_q;
    assign bus.reg_write_data   = wdata_q;
    assign bus.busy             = busy_q;
    assign bus.mem_timeout_err  = err_q;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe: the driver queues expected register writes with
// the edge they must appear on; a negedge monitor pops and compares every write.
module tb_wb_stage_pipe;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int MT   = 4;
    localparam int STEP = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wb_stage_pipe_if #(.XLEN(XLEN), .RADDR_W(RW)) bus ();

    wb_stage_pipe #(
        .XLEN(XLEN), .PC_STEP(STEP), .RADDR_W(RW), .MEM_TIMEOUT(MT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0]   addr;
        logic [XLEN-1:0] data;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    logic err_exp  = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at edge %0d", name, act, req, edge_n);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard on the expected edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
            mon_e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_write addr=%0d data=0x%h required at edge %0d, now edge %0d",
                     mon_e.addr, mon_e.data, mon_e.cyc, edge_n);
        end
        if (bus.reg_write_enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=0x%h at edge %0d required=no write",
                         bus.reg_write_addr, bus.reg_write_data, edge_n);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.reg_write_addr !== mon_e.addr || bus.reg_write_data !== mon_e.data ||
                    edge_n != mon_e.cyc) begin
                    failures++;
                    $display("FAIL write actual addr=%0d data=0x%h edge=%0d required addr=%0d data=0x%h edge=%0d",
                             bus.reg_write_addr, bus.reg_write_data, edge_n,
                             mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [2:0] f3,
                                               input logic [2:0] lo);
        logic [31:0] b;
        logic [31:0] h;
        b = (raw >> (8 * lo[1:0])) & 32'h0000_00FF;
        h = (raw >> (16 * lo[1])) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return raw;
        endcase
    endfunction

    task automatic send_alu(input logic [RW-1:0] rd, input logic regw, input logic [1:0] sel,
                            input logic [31:0] ex, input logic [31:0] pc, input logic [31:0] exp_data);
        check("ready_on_issue", bus.in_ready, 1);
        check("busy_on_issue", bus.busy, 0);
        bus.in_valid      = 1'b1;
        bus.in_regwrite   = regw;
        bus.in_rd         = rd;
        bus.in_wb_sel     = sel;
        bus.in_ex_result  = ex;
        bus.in_pc         = pc;
        bus.in_ld_funct3  = 3'($urandom_range(0, 7));
        bus.in_addr_lo    = 3'($urandom_range(0, 7));
        bus.mem_rsp_valid = 1'($urandom_range(0, 1));
        bus.mem_rsp_data  = $urandom;
        if (regw && rd != 5'd0) exp_q.push_back('{addr: rd, data: exp_data, cyc: edge_n + 1});
        @(negedge clk);
        bus.in_valid      = 1'b0;
        bus.mem_rsp_valid = 1'b0;
    endtask

    // k = edges after acceptance at which the response is sampled; k > MT means never.
    task automatic send_load(input logic [RW-1:0] rd, input logic regw, input logic [2:0] f3,
                             input logic [2:0] lo, input logic [31:0] raw, input int k,
                             input logic [31:0] exp_data);
        int acc;
        int n;
        check("ready_on_issue", bus.in_ready, 1);
        bus.in_valid      = 1'b1;
        bus.in_regwrite   = regw;
        bus.in_rd         = rd;
        bus.in_wb_sel     = 2'd1;
        bus.in_ex_result  = $urandom;
        bus.in_pc         = $urandom;
        bus.in_ld_funct3  = f3;
        bus.in_addr_lo    = lo;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = $urandom;
        acc = edge_n + 1;
        if (regw && rd != 5'd0 && k <= MT) exp_q.push_back('{addr: rd, data: exp_data, cyc: acc + k});
        @(negedge clk);
        n = (k < MT) ? k : MT;
        for (int j = 1; j <= n; j++) begin
            check("busy_in_wait", bus.busy, 1);
            check("ready_in_wait", bus.in_ready, 0);
            bus.in_valid      = 1'($urandom_range(0, 1));
            bus.in_wb_sel     = 2'd0;
            bus.in_regwrite   = 1'b1;
            bus.in_rd         = 5'd31;
            bus.mem_rsp_valid = (j == k);
            bus.mem_rsp_data  = (j == k) ? raw : $urandom;
            @(negedge clk);
        end
        bus.in_valid      = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        if (k > MT) err_exp = 1'b1;
        check("busy_after_load", bus.busy, 0);
        check("ready_after_load", bus.in_ready, 1);
        check("timeout_err", bus.mem_timeout_err, err_exp);
    endtask

    initial begin
        logic [RW-1:0] rd;
        logic [31:0]   ex, pc, raw;
        logic [2:0]    f3, lo;
        logic [1:0]    sel;
        logic          regw;

        bus.in_valid = 1'b0; bus.in_regwrite = 1'b0; bus.in_rd = '0; bus.in_wb_sel = 2'd0;
        bus.in_ex_result = '0; bus.in_pc = '0; bus.in_ld_funct3 = 3'd0; bus.in_addr_lo = 3'd0;
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;

        repeat (2) @(negedge clk);
        check("rst_we", bus.reg_write_enable, 0);
        check("rst_addr", bus.reg_write_addr, 0);
        check("rst_data", bus.reg_write_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.mem_timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);

        // Back-to-back ALU writes.
        send_alu(5'd1, 1'b1, 2'd0, 32'h11, 32'h0, 32'h11);
        send_alu(5'd2, 1'b1, 2'd0, 32'h22, 32'h0, 32'h22);
        send_alu(5'd3, 1'b1, 2'd3, 32'h33, 32'h0, 32'h33);

        // Sub-word loads from 0x80FF7F01.
        send_load(5'd10, 1'b1, 3'b000, 3'd3, 32'h80FF7F01, 2, 32'hFFFFFF80);
        send_load(5'd11, 1'b1, 3'b100, 3'd3, 32'h80FF7F01, 1, 32'h00000080);
        send_load(5'd12, 1'b1, 3'b001, 3'd2, 32'h80FF7F01, 3, 32'hFFFF80FF);
        send_load(5'd13, 1'b1, 3'b101, 3'd0, 32'h80FF7F01, 2, 32'h00007F01);
        send_load(5'd14, 1'b1, 3'b010, 3'd0, 32'h80FF7F01, MT, 32'h80FF7F01);

        // Link writes, including wrap-around.
        send_alu(5'd4, 1'b1, 2'd2, 32'h5555, 32'hFFFFFFFC, 32'h00000000);
        send_alu(5'd5, 1'b1, 2'd2, 32'h5555, 32'h00000100, 32'h00000104);

        // x0 and regwrite=0 never write; a load to x0 still waits.
        send_alu(5'd0, 1'b1, 2'd0, 32'hDEAD, 32'h0, 32'h0);
        send_alu(5'd5, 1'b0, 2'd0, 32'hBEEF, 32'h0, 32'h0);
        send_load(5'd0, 1'b1, 3'b010, 3'd0, 32'h12345678, 2, 32'h0);

        // Watchdog expiry, then the flag sticks across later work.
        send_load(5'd9, 1'b1, 3'b010, 3'd0, 32'h0, MT + 5, 32'h0);
        send_alu(5'd6, 1'b1, 2'd0, 32'h66, 32'h0, 32'h66);
        send_load(5'd7, 1'b1, 3'b100, 3'd1, 32'h0000AB00, 1, 32'h000000AB);
        check("err_sticky", bus.mem_timeout_err, 1);

        // Asynchronous reset in the middle of a load; a late response must be dropped.
        bus.in_valid = 1'b1; bus.in_wb_sel = 2'd1; bus.in_rd = 5'd8; bus.in_regwrite = 1'b1;
        bus.in_ld_funct3 = 3'b010;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("busy_before_rst", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", bus.reg_write_enable, 0);
        check("mid_rst_addr", bus.reg_write_addr, 0);
        check("mid_rst_data", bus.reg_write_data, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_err", bus.mem_timeout_err, 0);
        err_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEADBEEF;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_ready", bus.in_ready, 1);

        // Randomised mix against the reference model.
        for (int i = 0; i < 80; i++) begin
            rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            regw = ($urandom_range(0, 4) != 0);
            ex   = $urandom;
            pc   = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                f3  = 3'($urandom_range(0, 7));
                lo  = 3'($urandom_range(0, 7));
                raw = $urandom;
                send_load(rd, regw, f3, lo, raw, $urandom_range(1, MT + 2), model_load(raw, f3, lo));
            end else begin
                case ($urandom_range(0, 2))
                    0:       sel = 2'd0;
                    1:       sel = 2'd2;
                    default: sel = 2'd3;
                endcase
                send_alu(rd, regw, sel, ex, pc, (sel == 2'd2) ? pc + 32'd4 : ex);
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
